// File: rtl/argmax_ctrl.sv
// Argmax sequencer: sweeps N scores, drives the max comparator, reports index/value.
// Optional ARGMAX_CHECK_EN adds err, flagging cmp_max disagreeing with local best.
module argmax_ctrl #(
   parameter int BIT = 8,
   parameter int N   = 10,
   parameter int AW  = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           abort,
   input  logic [AW-1:0]  base_addr,
   output logic           rd_en,
   output logic [AW-1:0]  rd_addr,
   input  logic [BIT-1:0] rd_data,
   output logic           cmp_load,
   output logic           cmp_enable,
   output logic [BIT-1:0] cmp_in,
   input  logic [BIT-1:0] cmp_max,
   output logic           busy,
   output logic           done,
   output logic [3:0]     result_idx,
   output logic [BIT-1:0] result_val
`ifdef ARGMAX_CHECK_EN
   ,
   output logic           err
`endif
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] READ  = 3'd1;
   localparam logic [2:0] DRAIN = 3'd2;
   localparam logic [2:0] CAPT  = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam logic [3:0] LAST = 4'(N - 1);

   logic [2:0]     state_q, state_d;
   logic [AW-1:0]  base_q, base_d;
   logic [3:0]     k_q, k_d;
   logic           vld_q, vld_d;
   logic [3:0]     j_q, j_d;
   logic [BIT-1:0] best_q, best_d;
   logic [3:0]     bidx_q, bidx_d;
   logic [3:0]     ridx_q, ridx_d;
   logic [BIT-1:0] rval_q, rval_d;
   logic           accept;
   logic           kill;
   logic           capt;

   assign accept = (state_q == IDLE) && start;
   assign kill   = (state_q != IDLE) && abort;
   assign capt   = (state_q == CAPT) && !abort;

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      k_d     = k_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = READ;
               base_d  = base_addr;
               k_d     = '0;
            end
         end
         READ: begin
            k_d = k_q + 4'd1;
            if (k_q == LAST) begin
               state_d = DRAIN;
               k_d     = '0;
            end
         end
         // k doubles as the drain counter: two cycles for comparator latency
         DRAIN: begin
            k_d = k_q + 4'd1;
            if (k_q == 4'd1) state_d = CAPT;
         end
         CAPT:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (kill) state_d = IDLE;
   end

   always_comb begin
      vld_d  = (state_q == READ) && !abort;
      j_d    = j_q;
      best_d = best_q;
      bidx_d = bidx_q;
      ridx_d = ridx_q;
      rval_d = rval_q;
      if (vld_q) begin
         j_d = j_q + 4'd1;
         if (j_q == 4'd0) begin
            best_d = rd_data;
            bidx_d = 4'd0;
         end else if ($signed(rd_data) > $signed(best_q)) begin
            best_d = rd_data;
            bidx_d = j_q;
         end
      end
      if (accept) j_d = '0;
      if (capt) begin
         ridx_d = bidx_q;
         rval_d = cmp_max;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         base_q  <= '0;
         k_q     <= '0;
         vld_q   <= 1'b0;
         j_q     <= '0;
         best_q  <= '0;
         bidx_q  <= '0;
         ridx_q  <= '0;
         rval_q  <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         k_q     <= k_d;
         vld_q   <= vld_d;
         j_q     <= j_d;
         best_q  <= best_d;
         bidx_q  <= bidx_d;
         ridx_q  <= ridx_d;
         rval_q  <= rval_d;
      end
   end

`ifdef ARGMAX_CHECK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (accept) err_d = 1'b0;
      else if (capt && (cmp_max != best_q)) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign err = err_q;
`endif

   assign rd_en      = (state_q == READ);
   assign rd_addr    = rd_en ? base_q + AW'(k_q) : '0;
   assign cmp_load   = vld_q && (j_q == 4'd0);
   assign cmp_enable = vld_q && (j_q != 4'd0);
   assign cmp_in     = vld_q ? rd_data : '0;
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign result_idx = ridx_q;
   assign result_val = rval_q;

endmodule
